// File: rtl/crc_frame_sched.sv
// Round-robin scheduler that buffers one whole frame from one of two sources and
// streams it gap-free into a shared 16-bit CRC engine, then returns CRC, id and length.
module crc_frame_sched #(
   parameter  int MAX_WORDS = 16,
   localparam int LEN_W     = $clog2(MAX_WORDS + 1)
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic [1:0]       s_valid,
   input  logic [31:0]      s_data,
   input  logic [1:0]       s_last,
   output logic [1:0]       s_ready,
   output logic [15:0]      crc_data,
   output logic             crc_valid,
   input  logic [15:0]      crc_result,
   input  logic             crc_done,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [15:0]      res_crc,
   output logic             res_id,
   output logic [LEN_W-1:0] res_len,
   output logic             res_trunc
);

   localparam int AW = $clog2(MAX_WORDS);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_STREAM = 3'd2,
      ST_WAIT   = 3'd3,
      ST_RESULT = 3'd4
   } state_t;

   state_t           r_state;
   logic             r_g;
   logic             r_rr_ptr;
   logic [LEN_W-1:0] r_wr_ptr;
   logic [LEN_W-1:0] r_rd_ptr;
   logic [LEN_W-1:0] r_len;
   logic             r_trunc;
   logic [15:0]      r_buf [MAX_WORDS];

   logic [1:0]       r_s_ready;
   logic             r_crc_valid;
   logic [15:0]      r_crc_data;
   logic             r_res_valid;
   logic [15:0]      r_res_crc;
   logic             r_res_id;
   logic [LEN_W-1:0] r_res_len;
   logic             r_res_trunc;

   logic             w_pick;
   logic [15:0]      w_word;
   logic             w_last;
   logic             w_beat;
   logic             w_full;
   logic             w_first;
   logic [LEN_W-1:0] w_wr_next;
   logic [LEN_W-1:0] w_rd_next;

   // Prefer rr_ptr on a tie; otherwise whichever source is asking.
   assign w_pick    = s_valid[r_rr_ptr] ? r_rr_ptr : ~r_rr_ptr;
   assign w_word    = r_g ? s_data[31:16] : s_data[15:0];
   assign w_last    = s_last[r_g];
   assign w_beat    = s_valid[r_g] & r_s_ready[r_g];
   assign w_full    = (r_wr_ptr == LEN_W'(MAX_WORDS - 1));
   assign w_first   = (r_wr_ptr == {LEN_W{1'b0}});
   assign w_wr_next = r_wr_ptr + LEN_W'(1);
   assign w_rd_next = r_rd_ptr + LEN_W'(1);

   assign s_ready   = r_s_ready;
   assign crc_data  = r_crc_data;
   assign crc_valid = r_crc_valid;
   assign res_valid = r_res_valid;
   assign res_crc   = r_res_crc;
   assign res_id    = r_res_id;
   assign res_len   = r_res_len;
   assign res_trunc = r_res_trunc;

   // Frame storage is plain data; a reset only has to forget the pointers.
   always_ff @(posedge clk_in) begin
      if (r_state == ST_LOAD && w_beat) begin
         r_buf[r_wr_ptr[AW-1:0]] <= w_word;
      end
   end

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_g         <= 1'b0;
         r_rr_ptr    <= 1'b0;
         r_wr_ptr    <= {LEN_W{1'b0}};
         r_rd_ptr    <= {LEN_W{1'b0}};
         r_len       <= {LEN_W{1'b0}};
         r_trunc     <= 1'b0;
         r_s_ready   <= 2'b00;
         r_crc_valid <= 1'b0;
         r_crc_data  <= 16'h0000;
         r_res_valid <= 1'b0;
         r_res_crc   <= 16'h0000;
         r_res_id    <= 1'b0;
         r_res_len   <= {LEN_W{1'b0}};
         r_res_trunc <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_wr_ptr <= {LEN_W{1'b0}};
               r_rd_ptr <= {LEN_W{1'b0}};
               if (|s_valid) begin
                  r_g       <= w_pick;
                  r_s_ready <= w_pick ? 2'b10 : 2'b01;
                  r_state   <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               if (w_beat) begin
                  r_wr_ptr <= w_wr_next;
                  if (w_last || w_full) begin
                     r_len       <= w_wr_next;
                     r_trunc     <= ~w_last;
                     r_s_ready   <= 2'b00;
                     r_rd_ptr    <= {LEN_W{1'b0}};
                     r_crc_valid <= 1'b1;
                     // A one-word frame is still being written, so bypass the buffer.
                     r_crc_data  <= w_first ? w_word : r_buf[0];
                     r_state     <= ST_STREAM;
                  end
               end
            end
            ST_STREAM: begin
               if (r_rd_ptr == r_len - LEN_W'(1)) begin
                  r_crc_valid <= 1'b0;
                  r_crc_data  <= 16'h0000;
                  r_state     <= ST_WAIT;
               end else begin
                  r_rd_ptr   <= w_rd_next;
                  r_crc_data <= r_buf[w_rd_next[AW-1:0]];
               end
            end
            ST_WAIT: begin
               if (crc_done) begin
                  r_res_crc   <= crc_result;
                  r_res_id    <= r_g;
                  r_res_len   <= r_len;
                  r_res_trunc <= r_trunc;
                  r_res_valid <= 1'b1;
                  r_state     <= ST_RESULT;
               end
            end
            ST_RESULT: begin
               if (res_ready) begin
                  r_res_valid <= 1'b0;
                  r_rr_ptr    <= ~r_g;
                  r_state     <= ST_IDLE;
               end
            end
            default: begin
               r_s_ready   <= 2'b00;
               r_crc_valid <= 1'b0;
               r_res_valid <= 1'b0;
               r_state     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_crc_frame_sched.sv
// Scoreboard bench for crc_frame_sched: random frame sources, a CRC engine model and a
// frame-level reference model that predicts each source's results in order.
module tb_crc_frame_sched;

   localparam int MAX_WORDS = 16;
   localparam int LEN_W     = $clog2(MAX_WORDS + 1);

   logic             clk_in;
   logic             rst;
   logic [1:0]       s_valid;
   logic [31:0]      s_data;
   logic [1:0]       s_last;
   logic [1:0]       s_ready;
   logic [15:0]      crc_data;
   logic             crc_valid;
   logic [15:0]      crc_result;
   logic             crc_done;
   logic             res_valid;
   logic             res_ready;
   logic [15:0]      res_crc;
   logic             res_id;
   logic [LEN_W-1:0] res_len;
   logic             res_trunc;

   logic        tb_v [2];
   logic [15:0] tb_d [2];
   logic        tb_l [2];

   assign s_valid = {tb_v[1], tb_v[0]};
   assign s_data  = {tb_d[1], tb_d[0]};
   assign s_last  = {tb_l[1], tb_l[0]};

   crc_frame_sched #(.MAX_WORDS(MAX_WORDS)) dut (
      .clk_in(clk_in), .rst(rst),
      .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
      .crc_data(crc_data), .crc_valid(crc_valid),
      .crc_result(crc_result), .crc_done(crc_done),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_crc(res_crc), .res_id(res_id), .res_len(res_len), .res_trunc(res_trunc)
   );

   initial begin
      clk_in = 1'b0;
      forever #5 clk_in = ~clk_in;
   end

   int n_vec;
   int n_err;

   typedef struct {
      logic [15:0] crc;
      int          len;
      logic        trunc;
   } exp_t;

   exp_t        exp_q0 [$];
   exp_t        exp_q1 [$];
   int          run_q  [$];
   logic [15:0] cur_crc [2];
   int          cur_n   [2];

   int          n_res;
   logic [15:0] last_crc;
   int          last_id;
   int          last_len;
   logic        last_trunc;
   int          id_hist [$];
   int          ready_mode;

   function automatic logic [15:0] crc_word(input logic [15:0] c, input logic [15:0] w);
      logic [15:0] x;
      x = c ^ w;
      for (int i = 0; i < 16; i++) x = x[15] ? ((x << 1) ^ 16'h1021) : (x << 1);
      return x;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // Engine: folds a word in each valid cycle, clears when idle, done on valid's falling edge.
   logic [15:0] eng_crc;
   logic        eng_pv;
   always @(posedge clk_in or posedge rst) begin
      if (rst) begin
         eng_crc <= 16'h0000;
         eng_pv  <= 1'b0;
      end else begin
         eng_pv  <= crc_valid;
         eng_crc <= crc_valid ? crc_word(eng_crc, crc_data) : 16'h0000;
      end
   end
   assign crc_result = eng_crc;
   assign crc_done   = eng_pv & ~crc_valid;

   // Reference model: a source's word stream splits into frames at s_last or MAX_WORDS words.
   task automatic model_accept(input int src, input logic [15:0] w, input logic last);
      exp_t e;
      cur_crc[src] = crc_word(cur_crc[src], w);
      cur_n[src]   = cur_n[src] + 1;
      if (last || cur_n[src] == MAX_WORDS) begin
         e.crc   = cur_crc[src];
         e.len   = cur_n[src];
         e.trunc = !last;
         if (src == 0) exp_q0.push_back(e);
         else          exp_q1.push_back(e);
         cur_crc[src] = 16'h0000;
         cur_n[src]   = 0;
      end
   endtask

   task automatic model_clear();
      exp_q0.delete();
      exp_q1.delete();
      run_q.delete();
      for (int s = 0; s < 2; s++) begin
         cur_crc[s] = 16'h0000;
         cur_n[s]   = 0;
      end
   endtask

   // Called at posedge+1; holds the word until the DUT takes it.
   task automatic send_word(input int src, input logic [15:0] w, input logic last, input int gap);
      logic rdy;
      int   t;
      for (int g = 0; g < gap; g++) begin
         tb_v[src] = 1'b0;
         @(posedge clk_in); #1;
      end
      tb_v[src] = 1'b1;
      tb_d[src] = w;
      tb_l[src] = last;
      t = 0;
      forever begin
         @(negedge clk_in);
         rdy = s_ready[src];
         @(posedge clk_in); #1;
         if (rdy && !rst) begin
            model_accept(src, w, last);
            break;
         end
         t++;
         if (t > 400) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout src%0d: got no s_ready, expected a beat", src);
            break;
         end
      end
   endtask

   task automatic wait_results(input int n);
      int t;
      t = 0;
      while (n_res < n && t < 600) begin
         @(posedge clk_in); #1;
         t++;
      end
      check("result_count", n_res, n);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_s_ready"},   s_ready,   2'b00);
      check({tag, "_crc_valid"}, crc_valid, 1'b0);
      check({tag, "_crc_data"},  crc_data,  16'h0000);
      check({tag, "_res_valid"}, res_valid, 1'b0);
      check({tag, "_res_crc"},   res_crc,   16'h0000);
      check({tag, "_res_id"},    res_id,    1'b0);
      check({tag, "_res_len"},   res_len,   0);
      check({tag, "_res_trunc"}, res_trunc, 1'b0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      model_clear();
      repeat (2) @(posedge clk_in);
      #1;
      rst = 1'b0;
      @(posedge clk_in); #1;
   endtask

   // Consumer readiness: 0 = stalled, 1 = always, 2 = random.
   initial begin
      res_ready = 1'b0;
      forever begin
         @(posedge clk_in); #1;
         res_ready = (ready_mode == 2) ? ($urandom_range(0, 1) == 1) : (ready_mode == 1);
      end
   end

   // Monitor: pops the scoreboard on each result handshake and checks stream/hold/fairness.
   initial begin
      int          run_len;
      logic        hold_v;
      logic [23:0] held;
      logic        fair_v;
      logic        fair_id;
      exp_t        e;
      run_len = 0;
      hold_v  = 1'b0;
      fair_v  = 1'b0;
      fair_id = 1'b0;
      forever begin
         @(negedge clk_in);
         if (rst) begin
            run_len = 0;
            hold_v  = 1'b0;
            fair_v  = 1'b0;
         end else begin
            if (s_ready != 2'b00) check("s_ready_onehot", s_ready == 2'b11, 1'b0);
            if (crc_valid) run_len++;
            else if (run_len > 0) begin
               run_q.push_back(run_len);
               run_len = 0;
            end
            if (hold_v) check("res_hold", {res_valid, res_crc, res_id, res_len, res_trunc}, held);
            if (res_valid && res_ready) begin
               hold_v = 1'b0;
               if ((res_id == 1'b0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0)) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL unexpected_result: got id %0d, expected no result", res_id);
               end else begin
                  e = (res_id == 1'b0) ? exp_q0.pop_front() : exp_q1.pop_front();
                  check("res_crc",   res_crc,   e.crc);
                  check("res_len",   res_len,   e.len);
                  check("res_trunc", res_trunc, e.trunc);
               end
               if (run_q.size() == 0) check("crc_run_present", 0, 1);
               else                   check("crc_run_len", run_q.pop_front(), res_len);
               if (fair_v) check("rr_fairness", res_id, fair_id);
               fair_v  = tb_v[~res_id];
               fair_id = ~res_id;
               last_crc   = res_crc;
               last_id    = res_id;
               last_len   = res_len;
               last_trunc = res_trunc;
               id_hist.push_back(res_id);
               n_res++;
            end else if (res_valid) begin
               hold_v = 1'b1;
               held   = {1'b1, res_crc, res_id, res_len, res_trunc};
            end else begin
               hold_v = 1'b0;
            end
         end
      end
   end

   task automatic rand_driver(input int src);
      int len;
      for (int f = 0; f < 30; f++) begin
         len = $urandom_range(1, MAX_WORDS + 3);
         for (int i = 0; i < len; i++) begin
            send_word(src, 16'($urandom), (i == len - 1), $urandom_range(0, 2));
         end
      end
      tb_v[src] = 1'b0;
   endtask

   initial begin
      int base;
      int t;
      n_vec = 0;
      n_err = 0;
      n_res = 0;
      ready_mode = 1;
      for (int s = 0; s < 2; s++) begin
         tb_v[s] = 1'b0;
         tb_d[s] = 16'h0000;
         tb_l[s] = 1'b0;
      end
      model_clear();
      rst = 1'b1;
      repeat (3) @(posedge clk_in);
      #1;
      check_reset_outputs("reset");
      rst = 1'b0;
      @(posedge clk_in); #1;

      // Single one-word frame from source 0.
      base = n_res;
      send_word(0, 16'h0001, 1'b1, 0);
      tb_v[0] = 1'b0;
      wait_results(base + 1);
      check("t1_crc", last_crc, 16'h1021);
      check("t1_id", last_id, 0);
      check("t1_len", last_len, 1);
      check("t1_trunc", last_trunc, 1'b0);

      // Two-word frame from source 1.
      base = n_res;
      send_word(1, 16'h0001, 1'b0, 0);
      send_word(1, 16'h0000, 1'b1, 0);
      tb_v[1] = 1'b0;
      wait_results(base + 1);
      check("t2_crc", last_crc, 16'h3730);
      check("t2_id", last_id, 1);
      check("t2_len", last_len, 2);

      // Repeated ties after reset alternate starting with source 0.
      do_reset();
      id_hist.delete();
      base = n_res;
      fork
         begin
            send_word(0, 16'h00a0, 1'b1, 0);
            send_word(0, 16'h00a1, 1'b1, 0);
            tb_v[0] = 1'b0;
         end
         begin
            send_word(1, 16'h00b0, 1'b1, 0);
            send_word(1, 16'h00b1, 1'b1, 0);
            tb_v[1] = 1'b0;
         end
      join
      wait_results(base + 4);
      for (int i = 0; i < 4; i++) begin
         check("t3_tie_order", (id_hist.size() > i) ? id_hist[i] : -1, i % 2);
      end

      // Source bubbles during LOAD still give a contiguous stream.
      base = n_res;
      send_word(0, 16'h0001, 1'b0, 0);
      send_word(0, 16'h0000, 1'b1, 3);
      tb_v[0] = 1'b0;
      wait_results(base + 1);
      check("t4_crc", last_crc, 16'h3730);
      check("t4_len", last_len, 2);

      // s_last exactly on word MAX_WORDS is not a truncation.
      base = n_res;
      for (int i = 0; i < MAX_WORDS; i++) send_word(0, 16'(i + 1), (i == MAX_WORDS - 1), 0);
      tb_v[0] = 1'b0;
      wait_results(base + 1);
      check("t5_full_len", last_len, MAX_WORDS);
      check("t5_full_trunc", last_trunc, 1'b0);

      // MAX_WORDS+1 zero words with no s_last: truncated frame, extra word starts the next.
      base = n_res;
      for (int i = 0; i <= MAX_WORDS; i++) send_word(0, 16'h0000, 1'b0, 0);
      wait_results(base + 1);
      check("t5_trunc_len", last_len, MAX_WORDS);
      check("t5_trunc_flag", last_trunc, 1'b1);
      check("t5_trunc_crc", last_crc, 16'h0000);
      send_word(0, 16'h0000, 1'b1, 0);
      tb_v[0] = 1'b0;
      wait_results(base + 2);
      check("t5_next_len", last_len, 2);
      check("t5_next_trunc", last_trunc, 1'b0);

      // Reset during STREAM.
      ready_mode = 0;
      base = n_res;
      send_word(0, 16'h1234, 1'b0, 0);
      send_word(0, 16'h5678, 1'b0, 0);
      send_word(0, 16'h9abc, 1'b1, 0);
      tb_v[0] = 1'b0;
      check("t6_in_stream", crc_valid, 1'b1);
      rst = 1'b1;
      #1;
      check_reset_outputs("t6_stream_rst");
      model_clear();
      repeat (2) @(posedge clk_in);
      #1;
      rst = 1'b0;
      @(posedge clk_in); #1;

      // Reset while a result is held against a stalled consumer.
      send_word(1, 16'h0001, 1'b1, 0);
      tb_v[1] = 1'b0;
      t = 0;
      while (!res_valid && t < 50) begin
         @(posedge clk_in); #1;
         t++;
      end
      check("t6_res_pending", res_valid, 1'b1);
      check("t6_res_pending_id", res_id, 1'b1);
      repeat (3) @(posedge clk_in);
      #1;
      rst = 1'b1;
      #1;
      check_reset_outputs("t6_result_rst");
      model_clear();
      repeat (2) @(posedge clk_in);
      #1;
      rst = 1'b0;
      ready_mode = 1;
      repeat (10) @(posedge clk_in);
      #1;
      check("t6_no_result", res_valid, 1'b0);
      check("t6_no_handshake", n_res, base);
      send_word(0, 16'h0001, 1'b1, 0);
      tb_v[0] = 1'b0;
      wait_results(base + 1);
      check("t6_fresh_crc", last_crc, 16'h1021);
      check("t6_fresh_id", last_id, 0);

      // Random traffic from both sources with a randomly stalling consumer.
      ready_mode = 2;
      fork
         rand_driver(0);
         rand_driver(1);
      join
      t = 0;
      while ((exp_q0.size() + exp_q1.size()) > 0 && t < 3000) begin
         @(posedge clk_in); #1;
         t++;
      end
      check("drain_q0", exp_q0.size(), 0);
      check("drain_q1", exp_q1.size(), 0);
      check("model_idle", cur_n[0] + cur_n[1], 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
